// File: rtl/keypad_entry_if.sv
// Keypad entry bundle: debounced key inputs, entry valid/ready handshake and display outputs.
// master = entry buffer side, slave = keypad/consumer/display side.
interface keypad_entry_if #(parameter int DIGITS = 4);
   localparam int LEN_W = $clog2(DIGITS + 1);

   logic [3:0]          key_code;
   logic                key_pressed;
   logic                entry_ready;
   logic                entry_valid;
   logic [4*DIGITS-1:0] entry_value;
   logic [LEN_W-1:0]    entry_len;
   logic [4*DIGITS-1:0] disp_digits;
   logic [DIGITS-1:0]   disp_mask;
   logic                key_reject;
   logic                timeout;

   modport master (
      input  key_code, key_pressed, entry_ready,
      output entry_valid, entry_value, entry_len, disp_digits, disp_mask, key_reject, timeout
   );

   modport slave (
      output key_code, key_pressed, entry_ready,
      input  entry_valid, entry_value, entry_len, disp_digits, disp_mask, key_reject, timeout
   );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: one event per key press, hex digits assembled into a value, presented on valid/ready.
// KEYPAD_BACKSPACE_EN turns key 0xF into backspace; otherwise 0xF is an ordinary digit.
module keypad_entry_buffer #(
   parameter int          DIGITS         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
   input  logic           clk,
   input  logic           rst,
   keypad_entry_if.master kif
);
   localparam int               BUF_W   = 4 * DIGITS;
   localparam int               LEN_W   = $clog2(DIGITS + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DIGITS);
   localparam logic [31:0]      TO_LAST = TIMEOUT_CYCLES - 32'd1;
`ifdef KEYPAD_BACKSPACE_EN
   localparam bit BS_EN = 1'b1;
`else
   localparam bit BS_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_PEND} state_t;

   state_t             state, state_n;
   logic               kp_q;
   logic [BUF_W-1:0]   buf_q, buf_n, val_q, val_n;
   logic [LEN_W-1:0]   len_q, len_n, elen_q, elen_n;
   logic [DIGITS-1:0]  mask_q, mask_n;
   logic [31:0]        cnt_q, cnt_n;
   logic               vld_q, vld_n, rej_q, rej_n, to_q, to_n;
   logic               ev, is_enter, is_clear, is_bs;

   assign ev       = kif.key_pressed & ~kp_q;
   assign is_enter = (kif.key_code == 4'hE);
   assign is_clear = (kif.key_code == 4'hC);
   assign is_bs    = BS_EN && (kif.key_code == 4'hF);

   always_comb begin
      state_n = state;
      buf_n   = buf_q;
      len_n   = len_q;
      val_n   = val_q;
      elen_n  = elen_q;
      vld_n   = vld_q;
      cnt_n   = cnt_q;
      rej_n   = 1'b0;
      to_n    = 1'b0;
      mask_n  = '0;
      if (state == S_PEND) begin
         // Handshake wins; any key in this cycle still sees PENDING and is rejected.
         if (vld_q && kif.entry_ready) begin
            buf_n   = '0;
            len_n   = '0;
            val_n   = '0;
            elen_n  = '0;
            vld_n   = 1'b0;
            state_n = S_IDLE;
         end
         rej_n = ev;
      end else if (ev) begin
         if (is_enter) begin
            if (len_q != '0) begin
               state_n = S_PEND;
               vld_n   = 1'b1;
               val_n   = buf_q;
               elen_n  = len_q;
               cnt_n   = '0;
            end else begin
               rej_n = 1'b1;
            end
         end else if (is_clear) begin
            buf_n   = '0;
            len_n   = '0;
            cnt_n   = '0;
            state_n = S_IDLE;
         end else if (is_bs) begin
            if (len_q != '0) begin
               buf_n   = buf_q >> 4;
               len_n   = len_q - 1'b1;
               cnt_n   = '0;
               state_n = (len_q == LEN_W'(1)) ? S_IDLE : S_ENTRY;
            end else begin
               rej_n = 1'b1;
            end
         end else if (len_q < LEN_MAX) begin
            buf_n   = (buf_q << 4) | BUF_W'(kif.key_code);
            len_n   = len_q + 1'b1;
            cnt_n   = '0;
            state_n = S_ENTRY;
         end else begin
            rej_n = 1'b1;
         end
      end else if (state == S_ENTRY && TIMEOUT_CYCLES != 0) begin
         if (cnt_q == TO_LAST) begin
            buf_n   = '0;
            len_n   = '0;
            cnt_n   = '0;
            to_n    = 1'b1;
            state_n = S_IDLE;
         end else begin
            cnt_n = cnt_q + 32'd1;
         end
      end
      for (int i = 0; i < DIGITS; i++) begin
         mask_n[i] = (i < int'(len_n));
      end
   end

   // kp_q resets high so a key held through reset release gives no event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         kp_q   <= 1'b1;
         buf_q  <= '0;
         len_q  <= '0;
         val_q  <= '0;
         elen_q <= '0;
         vld_q  <= 1'b0;
         cnt_q  <= '0;
         rej_q  <= 1'b0;
         to_q   <= 1'b0;
         mask_q <= '0;
      end else begin
         state  <= state_n;
         kp_q   <= kif.key_pressed;
         buf_q  <= buf_n;
         len_q  <= len_n;
         val_q  <= val_n;
         elen_q <= elen_n;
         vld_q  <= vld_n;
         cnt_q  <= cnt_n;
         rej_q  <= rej_n;
         to_q   <= to_n;
         mask_q <= mask_n;
      end
   end

   assign kif.entry_valid = vld_q;
   assign kif.entry_value = val_q;
   assign kif.entry_len   = elen_q;
   assign kif.disp_digits = buf_q;
   assign kif.disp_mask   = mask_q;
   assign kif.key_reject  = rej_q;
   assign kif.timeout     = to_q;
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: key-sequence vector table plus hand-written timeout/pending/reset sequences.
module tb_keypad_entry_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   fails = 0;
   int   rej_cnt = 0;

   keypad_entry_if #(.DIGITS(4)) kif ();

   keypad_entry_buffer #(.DIGITS(4), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk),
      .rst(rst),
      .kif(kif.master)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (kif.key_reject) rej_cnt++;

   typedef struct {
      string       name;
      logic [31:0] keys;
      int          n;
      logic [15:0] val;
      int          len;
      int          rej;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] code);
      @(negedge clk);
      kif.key_code    = code;
      kif.key_pressed = 1'b1;
      repeat (10) @(negedge clk);
      kif.key_pressed = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      int first;
      int n_to;
      logic [3:0] k;

      vt[0] = '{"v_123", 32'h0000E321, 4, 16'h0123, 3, 0};
      vt[1] = '{"v_full", 32'h00E54321, 6, 16'h1234, 4, 1};
      vt[3] = '{"v_empty_enter", 32'h00000EAE, 3, 16'h000A, 1, 1};
      vt[4] = '{"v_clear", 32'h00E3CC21, 6, 16'h0003, 1, 0};
`ifdef KEYPAD_BACKSPACE_EN
      vt[2] = '{"v_bs", 32'h000E9F87, 5, 16'h0079, 2, 0};
      vt[5] = '{"v_bs_empty", 32'h00000E5F, 3, 16'h0005, 1, 1};
      vt[6] = '{"v_bs_multi", 32'h0E6FFF21, 7, 16'h0006, 1, 1};
`else
      vt[2] = '{"v_bs", 32'h000E9F87, 5, 16'h78F9, 4, 0};
      vt[5] = '{"v_bs_empty", 32'h00000E5F, 3, 16'h00F5, 2, 0};
      vt[6] = '{"v_bs_multi", 32'h0E6FFF21, 7, 16'h12FF, 4, 2};
`endif

      kif.key_code    = 4'h0;
      kif.key_pressed = 1'b0;
      kif.entry_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", kif.entry_valid, 0);
      chk("rst_value", kif.entry_value, 0);
      chk("rst_len", kif.entry_len, 0);
      chk("rst_digits", kif.disp_digits, 0);
      chk("rst_mask", kif.disp_mask, 0);
      chk("rst_reject", kif.key_reject, 0);
      chk("rst_timeout", kif.timeout, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         rej_cnt = 0;
         for (int j = 0; j < vt[v].n; j++) begin
            k = vt[v].keys[4*j +: 4];
            press(k);
         end
         chk({vt[v].name, "_valid"}, kif.entry_valid, 1);
         chk({vt[v].name, "_value"}, kif.entry_value, vt[v].val);
         chk({vt[v].name, "_len"}, kif.entry_len, vt[v].len);
         chk({vt[v].name, "_rej"}, rej_cnt, vt[v].rej);
         @(negedge clk);
         kif.entry_ready = 1'b1;
         @(negedge clk);
         kif.entry_ready = 1'b0;
         chk({vt[v].name, "_drop"}, kif.entry_valid, 0);
         chk({vt[v].name, "_mask0"}, kif.disp_mask, 0);
         chk({vt[v].name, "_elen0"}, kif.entry_len, 0);
      end

      // Timeout: pulse seen at the 101st negedge after driving the key (after edge N+100).
      @(negedge clk);
      kif.key_code    = 4'h5;
      kif.key_pressed = 1'b1;
      first = 0;
      n_to  = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("lat_mask", kif.disp_mask, 4'b0001);
            chk("lat_digits", kif.disp_digits, 16'h0005);
         end
         if (c == 10) kif.key_pressed = 1'b0;
         if (kif.timeout) begin
            n_to++;
            if (first == 0) first = c;
         end
      end
      chk("to_when", first, 101);
      chk("to_pulses", n_to, 1);
      chk("to_mask", kif.disp_mask, 0);

      // A press on the terminal-count edge is processed and suppresses the timeout.
      @(negedge clk);
      kif.key_code    = 4'h5;
      kif.key_pressed = 1'b1;
      n_to = 0;
      for (int c = 1; c <= 150; c++) begin
         @(negedge clk);
         if (c == 10 || c == 110) kif.key_pressed = 1'b0;
         if (c == 100) begin
            kif.key_code    = 4'h6;
            kif.key_pressed = 1'b1;
         end
         if (kif.timeout) n_to++;
      end
      chk("term_no_to", n_to, 0);
      chk("term_digits", kif.disp_digits, 16'h0056);
      chk("term_mask", kif.disp_mask, 4'b0011);
      press(4'hC);
      chk("clr_mask", kif.disp_mask, 0);

      // PENDING: valid rises right after enter, clear is rejected, handshake+press rejects the key.
      press(4'h1);
      press(4'h2);
      @(negedge clk);
      kif.key_code    = 4'hE;
      kif.key_pressed = 1'b1;
      @(negedge clk);
      chk("pend_rise", kif.entry_valid, 1);
      chk("pend_value", kif.entry_value, 16'h0012);
      repeat (9) @(negedge clk);
      kif.key_pressed = 1'b0;
      repeat (10) @(negedge clk);
      rej_cnt = 0;
      press(4'hC);
      chk("pend_clr_rej", rej_cnt, 1);
      chk("pend_clr_valid", kif.entry_valid, 1);
      chk("pend_clr_value", kif.entry_value, 16'h0012);
      chk("pend_clr_len", kif.entry_len, 2);
      @(negedge clk);
      kif.entry_ready = 1'b1;
      kif.key_code    = 4'h3;
      kif.key_pressed = 1'b1;
      @(negedge clk);
      kif.entry_ready = 1'b0;
      chk("hs_valid", kif.entry_valid, 0);
      chk("hs_reject", kif.key_reject, 1);
      chk("hs_mask", kif.disp_mask, 0);
      repeat (9) @(negedge clk);
      kif.key_pressed = 1'b0;
      repeat (10) @(negedge clk);
      chk("hs_idle_mask", kif.disp_mask, 0);

      // Reset in PENDING with a key held through reset release.
      press(4'h4);
      press(4'hE);
      chk("rp_valid", kif.entry_valid, 1);
      @(negedge clk);
      kif.key_code    = 4'h7;
      kif.key_pressed = 1'b1;
      rst = 1'b1;
      #1;
      chk("rp_async", kif.entry_valid, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rej_cnt = 0;
      repeat (10) @(negedge clk);
      chk("held_mask", kif.disp_mask, 0);
      chk("held_rej", rej_cnt, 0);
      kif.key_pressed = 1'b0;
      repeat (5) @(negedge clk);
      press(4'h7);
      chk("held_again_mask", kif.disp_mask, 4'b0001);
      chk("held_again_digits", kif.disp_digits, 16'h0007);
      press(4'hC);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
